bus_copy_master: RTL and testbench

- Bus initiator for the processor's shared 8-bit peripheral bus.
- Performs the other end of the protocol that memory-mapped peripherals respond to. It drives BUS_ADDR and BUS_WE, and either drives or samples BUS_DATA.
- Copies LENGTH bytes from a source address range to a destination address range, one read cycle followed by one write cycle per byte.
- Owns the bus only while BUS_GNT is high; the processor is the arbiter and default owner.

---
 rtl/bus_copy_master_pkg.sv | 23 ++
 rtl/bus_copy_master_bus_tristate_driver.sv | 23 ++
 rtl/bus_copy_master.sv | 122 ++++++++++++
 tb/tb_bus_copy_master.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_copy_master_pkg.sv
// Shared definitions for the copy master: bus widths common to the
// peripherals and address decoder, plus the FSM state encoding.
package bus_copy_master_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;
  localparam int LEN_WIDTH  = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQ    = 3'd1;
  localparam logic [2:0] ST_READ   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    REQ    = ST_REQ,
    READ   = ST_READ,
    WRITE  = ST_WRITE,
    FINISH = ST_FINISH
  } state_e;

endpackage

// File: rtl/bus_copy_master_bus_tristate_driver.sv
// Grant-gated high-Z drivers for the shared peripheral bus. Enables are
// combinational so the bus is let go in the same cycle the grant drops.
module bus_tristate_driver #(
  parameter int ADDR_WIDTH = bus_copy_master_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_copy_master_pkg::DATA_WIDTH
) (
  input  logic                  bus_en,
  input  logic                  data_en,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  inout  wire  [DATA_WIDTH-1:0] bus_data
);

  assign bus_addr = bus_en  ? addr_i : {ADDR_WIDTH{1'bz}};
  assign bus_we   = bus_en  ? we_i   : 1'bz;
  assign bus_data = data_en ? data_i : {DATA_WIDTH{1'bz}};
  assign data_o   = bus_data;

endmodule

// File: rtl/bus_copy_master.sv
// Bus initiator copying LENGTH bytes from SRC_ADDR to DST_ADDR, one read
// then one write per byte, holding its place whenever the grant is withdrawn.
//
// state  | meaning
// IDLE   | waiting for START
// REQ    | BUS_REQ raised, waiting for BUS_GNT
// READ   | drive src address, latch BUS_DATA on a granted edge
// WRITE  | drive dst address and latched byte, advance counters on a granted edge
// FINISH | one-cycle DONE pulse
module bus_copy_master #(
  parameter int ADDR_WIDTH = bus_copy_master_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bus_copy_master_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = bus_copy_master_pkg::LEN_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
  input  logic [ADDR_WIDTH-1:0] DST_ADDR,
  input  logic [LEN_WIDTH-1:0]  LENGTH,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  BUS_REQ,
  input  logic                  BUS_GNT,
  output logic [ADDR_WIDTH-1:0] BUS_ADDR,
  output logic                  BUS_WE,
  inout  wire  [DATA_WIDTH-1:0] BUS_DATA
);
  import bus_copy_master_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] bus_rd_data;
  logic                  bus_en;
  logic                  data_en;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (LENGTH != '0) begin
            src_d   = SRC_ADDR;
            dst_d   = DST_ADDR;
            len_d   = LENGTH;
            state_d = REQ;
          end else begin
            state_d = FINISH;
          end
        end
      end
      REQ: begin
        if (BUS_GNT) state_d = READ;
      end
      READ: begin
        if (BUS_GNT) begin
          data_d  = bus_rd_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Without grant nothing advances, so the same byte is re-written later.
        if (BUS_GNT) begin
          src_d   = src_q + ADDR_ONE;
          dst_d   = dst_q + ADDR_ONE;
          len_d   = len_q - LEN_ONE;
          state_d = (len_q == LEN_ONE) ? FINISH : READ;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY    = (state_q == REQ) || (state_q == READ) || (state_q == WRITE);
  assign BUS_REQ = BUSY;
  assign DONE    = (state_q == FINISH);
  assign bus_en  = ((state_q == READ) || (state_q == WRITE)) && BUS_GNT;
  assign data_en = (state_q == WRITE) && BUS_GNT;

  bus_tristate_driver #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_drv (
    .bus_en  (bus_en),
    .data_en (data_en),
    .addr_i  ((state_q == WRITE) ? dst_q : src_q),
    .we_i    (state_q == WRITE),
    .data_i  (data_q),
    .data_o  (bus_rd_data),
    .bus_addr(BUS_ADDR),
    .bus_we  (BUS_WE),
    .bus_data(BUS_DATA)
  );

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: RAM responder on the shared bus, expected writes
// queued at START and popped as granted writes appear, per-cycle bus checks.
module tb_bus_copy_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       gnt;
  logic [7:0] src_in, dst_in, len_in;
  logic       busy, done, req;
  wire  [7:0] bus_addr;
  wire        bus_we;
  wire  [7:0] bus_data;

  // Released bus reads back as addr=FF, we=0 through the pulls.
  localparam logic [8:0] REL = 9'h0FF;

  logic [7:0] ram    [256];
  logic [7:0] shadow [256];
  logic       ram_load;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup pu_a (bus_addr[g]);
    pullup pu_d (bus_data[g]);
  end
  pulldown pd_we (bus_we);

  assign bus_data = (bus_we == 1'b0) ? ram[bus_addr] : 8'bz;

  bus_copy_master dut (
    .CLK     (clk),
    .RESET   (rst),
    .START   (start),
    .SRC_ADDR(src_in),
    .DST_ADDR(dst_in),
    .LENGTH  (len_in),
    .BUSY    (busy),
    .DONE    (done),
    .BUS_REQ (req),
    .BUS_GNT (gnt),
    .BUS_ADDR(bus_addr),
    .BUS_WE  (bus_we),
    .BUS_DATA(bus_data)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seed(input int i);
    case (i)
      16:      return 8'hA5;
      17:      return 8'h3C;
      18:      return 8'h7E;
      default: return 8'((i * 37 + 11) ^ 8'h5A);
    endcase
  endfunction

  // Write monitor: a granted write seen mid-cycle commits at the next edge.
  always begin : mon
    wr_t e;
    @(negedge clk);
    #2;
    if (ram_load) begin
      for (int i = 0; i < 256; i++) ram[i] = seed(i);
    end else if (!rst && gnt && bus_we === 1'b1) begin
      ram[bus_addr] = bus_data;
      if (sb_q.size() == 0) begin
        check_eq("sb_extra_wr", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("wr_addr", 32'(bus_addr), 32'(e.addr));
        check_eq("wr_data", 32'(bus_data), 32'(e.data));
      end
    end
  end

  // One transfer with grant dropped for cycles [ds, ds+dl) counted from the
  // START edge; poke re-strobes START with other arguments mid-transfer.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int ds, input int dl, input bit poke);
    int         n;
    int         e;
    bit         fin;
    logic [7:0] v;
    logic [8:0] exp_bus;
    logic       exp_busy, exp_done;
    n   = int'(l);
    fin = 1'b0;
    @(negedge clk);
    start  = 1'b1;
    src_in = s;
    dst_in = d;
    len_in = l;
    gnt    = 1'b1;
    #1;
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < n; i++) begin
      v = shadow[8'(int'(s) + i)];
      shadow[8'(int'(d) + i)] = v;
      sb_q.push_back('{addr: 8'(int'(d) + i), data: v});
    end
    for (int j = 0; j < 2 * n + dl + 4 && !fin; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && j == 2) begin
        start  = 1'b1;
        src_in = 8'h80;
        dst_in = 8'h90;
        len_in = 8'd5;
      end
      gnt = !(j >= ds && j < ds + dl);
      #1;
      if (n == 0) begin
        exp_done = (j == 0);
        exp_busy = 1'b0;
        exp_bus  = REL;
      end else if (j >= ds && j < ds + dl) begin
        exp_done = 1'b0;
        exp_busy = 1'b1;
        exp_bus  = REL;
      end else begin
        e        = (j >= ds + dl) ? j - dl : j;
        exp_done = (e == 2 * n + 1);
        exp_busy = (e <= 2 * n);
        if (e == 0 || e > 2 * n)  exp_bus = REL;
        else if (e % 2 == 1)      exp_bus = {1'b0, 8'(int'(s) + (e - 1) / 2)};
        else                      exp_bus = {1'b1, 8'(int'(d) + e / 2 - 1)};
      end
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("req",  32'(req),  32'(exp_busy));
      check_eq("done", 32'(done), 32'(exp_done));
      check_eq("bus",  32'({bus_we, bus_addr}), 32'(exp_bus));
      if (exp_done) fin = 1'b1;
    end
    start = 1'b0;
    check_eq("done_reached", 32'(fin), 32'd1);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    gnt      = 1'b1;
    src_in   = '0;
    dst_in   = '0;
    len_in   = '0;
    ram_load = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = seed(i);
    repeat (3) @(negedge clk);
    ram_load = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_req",  32'(req),  32'd0);
    check_eq("rst_bus",  32'({bus_we, bus_addr}), 32'(REL));
    @(negedge clk);
    rst = 1'b0;

    // basic copy, then zero length in the cycle right after DONE
    run_xfer(8'h10, 8'h40, 8'd3, 999, 0, 1'b0);
    run_xfer(8'h20, 8'h50, 8'd0, 999, 0, 1'b0);
    check_eq("basic_40", 32'(ram[8'h40]), 32'h0A5);
    check_eq("basic_41", 32'(ram[8'h41]), 32'h03C);
    check_eq("basic_42", 32'(ram[8'h42]), 32'h07E);

    // grant withdrawn for 3 cycles during the second write
    run_xfer(8'h10, 8'h60, 8'd3, 4, 3, 1'b0);
    check_eq("gnt_61", 32'(ram[8'h61]), 32'h03C);
    check_eq("gnt_62", 32'(ram[8'h62]), 32'h07E);

    // address wrap with overlapping ranges
    run_xfer(8'hFE, 8'hFF, 8'd3, 999, 0, 1'b0);
    check_eq("wrap_ff", 32'(ram[8'hFF]), 32'(seed(254)));
    check_eq("wrap_00", 32'(ram[8'h00]), 32'(seed(254)));
    check_eq("wrap_01", 32'(ram[8'h01]), 32'(seed(254)));

    // START while busy is ignored
    run_xfer(8'h20, 8'h70, 8'd4, 999, 0, 1'b1);

    // reset during the first READ
    @(negedge clk);
    start  = 1'b1;
    src_in = 8'h10;
    dst_in = 8'h88;
    len_in = 8'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check_eq("pre_rst_bus", 32'({bus_we, bus_addr}), 32'h010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req",  32'(req),  32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_done", 32'(done), 32'd0);
    check_eq("mid_rst_bus",  32'({bus_we, bus_addr}), 32'(REL));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("post_rst_done", 32'(done), 32'd0);
    end
    check_eq("post_rst_88", 32'(ram[8'h88]), 32'(seed(136)));
    run_xfer(8'h30, 8'h58, 8'd2, 999, 0, 1'b0);

    repeat (2) @(negedge clk);
    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
